// File: rtl/enoc_wormhole_output_arbiter_pkg.sv
// rtl/enoc_wormhole_output_arbiter_pkg.sv - shared types and helpers for the ENoC output arbiter
package enoc_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Wrap-around increment that stays correct for non-power-of-2 port counts.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/enoc_wormhole_output_arbiter_if.sv
// rtl/enoc_wormhole_output_arbiter_if.sv - request/grant bundle between input units, arbiter and crossbar
interface enoc_wormhole_output_arbiter_if #(
  parameter int N = 5,
  parameter int M = 5
);
  import enoc_arb_pkg::*;

  logic [M-1:0]         i_en;
  logic [N-1:0][M-1:0]  i_output_req;
  logic [N-1:0]         i_tail;
  logic [M-1:0][N-1:0]  o_output_grant;
  logic [M-1:0]         o_locked;

  modport master (
    output i_en, i_output_req, i_tail,
    input  o_output_grant, o_locked
  );

  modport slave (
    input  i_en, i_output_req, i_tail,
    output o_output_grant, o_locked
  );
endinterface

// File: rtl/enoc_wormhole_output_arbiter_rr_lock.sv
// rtl/enoc_wormhole_output_arbiter_rr_lock.sv - one output: round-robin pick, packet lock, owner and pointer
module enoc_rr_lock_arbiter
  import enoc_arb_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ce,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic [N-1:0] tail,
  output logic [N-1:0] grant,
  output logic         locked
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  arb_state_t state_q, state_d;
  logic [W-1:0] owner_q, owner_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] winner;
  logic [W-1:0] cand;
  logic         found;
  int           idx;

  // State, owner and pointer registers; next values are already gated by ce.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else if (ce) begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Round-robin search from ptr, then grant/lock decisions for this output.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant   = '0;
    found   = 1'b0;
    winner  = '0;
    cand    = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      cand = W'(idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    case (state_q)
      ARB_IDLE: begin
        if (ce && en && found) begin
          grant[winner] = 1'b1;
          if (tail[winner]) begin
            ptr_d = W'(rr_next(32'(winner), N));
          end else begin
            owner_d = winner;
            state_d = ARB_LOCKED;
          end
        end
      end
      ARB_LOCKED: begin
        if (ce && en && req[owner_q]) begin
          grant[owner_q] = 1'b1;
          if (tail[owner_q]) begin
            state_d = ARB_IDLE;
            ptr_d   = W'(rr_next(32'(owner_q), N));
          end
        end
      end
    endcase
  end

  assign locked = (state_q == ARB_LOCKED);

endmodule

// File: rtl/enoc_wormhole_output_arbiter.sv
// rtl/enoc_wormhole_output_arbiter.sv - per-output wormhole packet-locking arbiter (option: ENOC_GRANT_PIPE_EN)
module enoc_wormhole_output_arbiter
  import enoc_arb_pkg::*;
#(
  parameter int N = 5,
  parameter int M = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  enoc_wormhole_output_arbiter_if.slave bus
);
  wire [M-1:0][N-1:0] grant_int;
  wire [M-1:0]        locked_int;

  for (genvar j = 0; j < M; j++) begin : g_out
    logic [N-1:0] req_col;

    // Transpose: collect every input's request for this output.
    always_comb begin
      req_col = '0;
      for (int i = 0; i < N; i++) req_col[i] = bus.i_output_req[i][j];
    end

    enoc_rr_lock_arbiter #(.N(N)) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .ce      (ce),
      .en      (bus.i_en[j]),
      .req     (req_col),
      .tail    (bus.i_tail),
      .grant   (grant_int[j]),
      .locked  (locked_int[j])
    );
  end

  for (genvar i = 0; i < N; i++) begin : g_chk
    a_req_onehot: assert property (@(posedge clk) disable iff (!reset_n)
      $onehot0(bus.i_output_req[i]));
  end

  assign bus.o_locked = locked_int;

`ifdef ENOC_GRANT_PIPE_EN
  logic [M-1:0][N-1:0] grant_q;

  // Retime the grant towards the crossbar; arbitration itself is unaffected.
  always_ff @(posedge clk) begin
    if (!reset_n) grant_q <= '0;
    else if (ce)  grant_q <= grant_int;
  end

  assign bus.o_output_grant = grant_q;
`else
  assign bus.o_output_grant = grant_int;
`endif

endmodule

// File: tb/tb_enoc_wormhole_output_arbiter.sv
// tb/tb_enoc_wormhole_output_arbiter.sv - directed self-checking bench for the wormhole output arbiter
module tb_enoc_wormhole_output_arbiter;
  localparam int N = 5;
  localparam int M = 5;

  logic clk;
  logic reset_n;
  logic ce;
  int   checks;
  int   errors;

  enoc_wormhole_output_arbiter_if #(.N(N), .M(M)) bus ();

  enoc_wormhole_output_arbiter #(.N(N), .M(M)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.i_en         = '1;
    bus.i_output_req = '0;
    bus.i_tail       = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    ce      = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.o_locked !== 5'b0) begin
      errors++;
      $display("FAIL reset_locked got=%b exp=%b", bus.o_locked, 5'b0);
    end
    checks++;
    if (bus.o_output_grant !== '0) begin
      errors++;
      $display("FAIL reset_grant got=%h exp=0", bus.o_output_grant);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_packet();
    logic [4:0] exp_l;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      bus.i_output_req = '0;
      bus.i_tail       = '0;
      if (c < 4) bus.i_output_req[0][2] = 1'b1;
      if (c == 3) bus.i_tail[0] = 1'b1;
      #1;
      checks++;
      if (bus.o_output_grant[2] !== ((c < 4) ? 5'b00001 : 5'b00000)) begin
        errors++;
        $display("FAIL pkt_grant c=%0d got=%b", c, bus.o_output_grant[2]);
      end
      exp_l = (c >= 1 && c <= 3) ? 5'b00100 : 5'b00000;
      checks++;
      if (bus.o_locked !== exp_l) begin
        errors++;
        $display("FAIL pkt_locked c=%0d got=%b exp=%b", c, bus.o_locked, exp_l);
      end
      tick();
    end
  endtask

  task automatic test_rr();
    logic [4:0] exp_g;
    do_reset();
    bus.i_output_req[1][4] = 1'b1;
    bus.i_output_req[3][4] = 1'b1;
    bus.i_tail[1] = 1'b1;
    bus.i_tail[3] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_g = (c % 2 == 0) ? 5'b00010 : 5'b01000;
      checks++;
      if (bus.o_output_grant[4] !== exp_g || bus.o_locked[4] !== 1'b0) begin
        errors++;
        $display("FAIL rr_grant c=%0d got=%b exp=%b locked=%b", c, bus.o_output_grant[4], exp_g, bus.o_locked[4]);
      end
      tick();
    end
  endtask

  task automatic test_bubble();
    logic [4:0] exp_g;
    do_reset();
    bus.i_tail[4] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.i_output_req[2][1] = (c == 0 || c == 2 || c == 3);
      bus.i_output_req[4][1] = (c >= 1);
      bus.i_tail[2] = (c == 3);
      #1;
      case (c)
        0, 2, 3: exp_g = 5'b00100;
        1:       exp_g = 5'b00000;
        default: exp_g = 5'b10000;
      endcase
      checks++;
      if (bus.o_output_grant[1] !== exp_g) begin
        errors++;
        $display("FAIL bubble_grant c=%0d got=%b exp=%b", c, bus.o_output_grant[1], exp_g);
      end
      if (c == 1) begin
        checks++;
        if (bus.o_locked[1] !== 1'b1) begin
          errors++;
          $display("FAIL bubble_locked got=%b exp=1", bus.o_locked[1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_enable();
    logic [4:0] exp_g;
    do_reset();
    bus.i_output_req[1][3] = 1'b1;
    bus.i_tail[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.i_output_req[0][3] = (c < 5);
      bus.i_tail[0] = (c == 4);
      bus.i_en[3] = !(c == 1 || c == 2);
      #1;
      case (c)
        0, 3, 4: exp_g = 5'b00001;
        1, 2:    exp_g = 5'b00000;
        default: exp_g = 5'b00010;
      endcase
      checks++;
      if (bus.o_output_grant[3] !== exp_g) begin
        errors++;
        $display("FAIL en_grant c=%0d got=%b exp=%b", c, bus.o_output_grant[3], exp_g);
      end
      if (c == 2) begin
        checks++;
        if (bus.o_locked[3] !== 1'b1) begin
          errors++;
          $display("FAIL en_locked got=%b exp=1", bus.o_locked[3]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.i_output_req[1][0] = 1'b1;
    bus.i_tail[1] = 1'b1;
    #1;
    checks++;
    if (bus.o_output_grant[0] !== 5'b00010) begin
      errors++;
      $display("FAIL rst_mid_single got=%b exp=%b", bus.o_output_grant[0], 5'b00010);
    end
    tick();
    bus.i_output_req = '0;
    bus.i_tail = '0;
    bus.i_output_req[3][0] = 1'b1;
    #1;
    checks++;
    if (bus.o_output_grant[0] !== 5'b01000) begin
      errors++;
      $display("FAIL rst_mid_head got=%b exp=%b", bus.o_output_grant[0], 5'b01000);
    end
    tick();
    checks++;
    if (bus.o_locked[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_locked got=%b exp=1", bus.o_locked[0]);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.i_output_req = '0;
    bus.i_output_req[0][0] = 1'b1;
    bus.i_output_req[4][0] = 1'b1;
    #1;
    checks++;
    if (bus.o_locked[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_unlock got=%b exp=0", bus.o_locked[0]);
    end
    checks++;
    if (bus.o_output_grant[0] !== 5'b00001) begin
      errors++;
      $display("FAIL rst_mid_ptr got=%b exp=%b", bus.o_output_grant[0], 5'b00001);
    end
    tick();
  endtask

  task automatic test_ce_low();
    do_reset();
    ce = 1'b0;
    bus.i_output_req[2][0] = 1'b1;
    #1;
    checks++;
    if (bus.o_output_grant !== '0) begin
      errors++;
      $display("FAIL ce_grant got=%h exp=0", bus.o_output_grant);
    end
    tick();
    checks++;
    if (bus.o_locked !== 5'b0) begin
      errors++;
      $display("FAIL ce_locked got=%b exp=0", bus.o_locked);
    end
    ce = 1'b1;
    clear_inputs();
  endtask

  task automatic test_pipe();
    logic [4:0] exp_g;
    do_reset();
    bus.i_output_req[1][4] = 1'b1;
    bus.i_output_req[3][4] = 1'b1;
    bus.i_tail[1] = 1'b1;
    bus.i_tail[3] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      if (c == 0) exp_g = 5'b00000;
      else exp_g = ((c - 1) % 2 == 0) ? 5'b00010 : 5'b01000;
      checks++;
      if (bus.o_output_grant[4] !== exp_g) begin
        errors++;
        $display("FAIL pipe_grant c=%0d got=%b exp=%b", c, bus.o_output_grant[4], exp_g);
      end
      tick();
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    ce      = 1'b1;
    reset_n = 1'b0;
    clear_inputs();
    test_reset();
`ifdef ENOC_GRANT_PIPE_EN
    test_pipe();
`else
    test_single_packet();
    test_rr();
    test_bubble();
    test_enable();
    test_reset_mid();
    test_ce_low();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
